// File: rtl/elev_req_sched.sv
// elev_req_sched: latches floor calls and issues one held one-hot request at a time
// to the elevator core, using direction-preserving (SCAN) target selection.
module elev_req_sched #(
    parameter int DWELL   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [3:1] Btn,
    input  logic       FLR1,
    input  logic       FLR2,
    input  logic       FLR3,
    input  logic       Door,
    input  logic       FaultClr,
    output logic [3:1] Req,
    output logic [3:1] Pend,
    output logic       Dir,
    output logic       Busy,
    output logic       Fault
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DWELL, S_FAULT} state_t;

    state_t      state, state_nx;
    logic [3:1]  btn_q, flr, set, clr, above, below, pa, pb, sel, req_nx, pend_nx;
    logic [1:0]  cur, up_t, dn_t, tgt;
    logic        pos_ok, here, flip, dir_nx;
    logic [15:0] cnt, cnt_nx;

    always_comb begin
        flr    = {FLR3, FLR2, FLR1};
        pos_ok = $onehot(flr);
        cur    = flr[3] ? 2'd3 : (flr[2] ? 2'd2 : 2'd1);
        // a press at the floor whose door is already open is answered by that opening
        set    = Btn & ~btn_q & ~(flr & {3{Door}});
        above  = (cur == 2'd1) ? 3'b110 : ((cur == 2'd2) ? 3'b100 : 3'b000);
        below  = (cur == 2'd3) ? 3'b011 : ((cur == 2'd2) ? 3'b001 : 3'b000);
        pa     = Pend & above;
        pb     = Pend & below;
        up_t   = pa[2] ? 2'd2 : 2'd3;
        dn_t   = pb[2] ? 2'd2 : 2'd1;
        here   = |(Pend & flr);
        flip   = !here && !(Dir ? |pa : |pb);
        tgt    = here ? cur : ((Dir ^ flip) ? up_t : dn_t);
        sel    = {tgt == 2'd3, tgt == 2'd2, tgt == 2'd1};
        state_nx = state;
        req_nx   = Req;
        cnt_nx   = cnt;
        dir_nx   = Dir;
        clr      = 3'b000;
        case (state)
            S_IDLE: begin
                req_nx = 3'b000;
                if (|Pend && pos_ok) begin
                    req_nx   = sel;
                    cnt_nx   = '0;
                    dir_nx   = Dir ^ flip;
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (Door && |(flr & Req)) begin
                    clr      = Req;
                    req_nx   = 3'b000;
                    cnt_nx   = 16'(DWELL);
                    state_nx = S_DWELL;
                end else begin
                    cnt_nx = cnt + 16'd1;
                    if (cnt_nx == 16'(TIMEOUT)) begin
                        req_nx   = 3'b000;
                        state_nx = S_FAULT;
                    end
                end
            end
            S_DWELL: begin
                req_nx = 3'b000;
                cnt_nx = (cnt == '0) ? '0 : cnt - 16'd1;
                if (cnt_nx == '0 && !Door) state_nx = S_IDLE;
            end
            default: begin
                req_nx = 3'b000;
                if (FaultClr) begin
                    cnt_nx   = '0;
                    state_nx = S_IDLE;
                end
            end
        endcase
        pend_nx = (Pend & ~clr) | set;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
            btn_q <= 3'b000;
            cnt   <= '0;
            Req   <= 3'b000;
            Pend  <= 3'b000;
            Dir   <= 1'b1;
            Busy  <= 1'b0;
            Fault <= 1'b0;
        end else begin
            state <= state_nx;
            btn_q <= Btn;
            cnt   <= cnt_nx;
            Req   <= req_nx;
            Pend  <= pend_nx;
            Dir   <= dir_nx;
            Busy  <= state_nx != S_IDLE;
            Fault <= state_nx == S_FAULT;
        end
    end
endmodule

// File: tb/tb_elev_req_sched.sv
// tb_elev_req_sched: directed scenarios plus random traffic, checked by a scoreboard
// fed from a floor-level reference model of the call scheduler.
module tb_elev_req_sched;
    localparam int DWELL   = 4;
    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic [3:1] Btn = 3'b000;
    logic       FLR1 = 1'b0, FLR2 = 1'b0, FLR3 = 1'b0;
    logic       Door = 1'b0, FaultClr = 1'b0;
    logic [3:1] Req, Pend;
    logic       Dir, Busy, Fault;

    elev_req_sched #(.DWELL(DWELL), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .Reset(Reset), .Btn(Btn), .FLR1(FLR1), .FLR2(FLR2), .FLR3(FLR3),
        .Door(Door), .FaultClr(FaultClr), .Req(Req), .Pend(Pend), .Dir(Dir),
        .Busy(Busy), .Fault(Fault)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [8:0] expq[$];

    // model: 0 idle, 1 serving target floor m_tgt, 2 dwelling, 3 faulted
    int m_state, m_tgt, m_tmo, m_dw;
    bit m_dir;
    bit m_pend[4];
    bit m_prev[4];

    task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_tgt = 0; m_tmo = 0; m_dw = 0; m_dir = 1'b1;
        for (int f = 0; f < 4; f++) begin
            m_pend[f] = 1'b0;
            m_prev[f] = 1'b0;
        end
    endtask

    function automatic logic [8:0] model_out();
        logic [3:1] r;
        r = (m_tgt == 0) ? 3'b000 : 3'(1 << (m_tgt - 1));
        return {r, m_pend[3], m_pend[2], m_pend[1], m_dir, m_state != 0, m_state == 3};
    endfunction

    task automatic model_step(input logic [3:1] b, input logic [3:1] fl, input logic d, input logic fc);
        int n, cur, clr, up, dn;
        bit any;
        bit setb[4];
        n = int'(fl[1]) + int'(fl[2]) + int'(fl[3]);
        cur = fl[3] ? 3 : (fl[2] ? 2 : 1);
        clr = 0; up = 0; dn = 0; any = 1'b0;
        setb[0] = 1'b0;
        for (int f = 1; f <= 3; f++) begin
            setb[f] = b[f] && !m_prev[f] && !(d && fl[f]);
            any |= m_pend[f];
        end
        for (int f = 3; f > cur; f--) if (m_pend[f]) up = f;
        for (int f = 1; f < cur; f++) if (m_pend[f]) dn = f;
        case (m_state)
            0: if (any && n == 1) begin
                if (m_pend[cur]) m_tgt = cur;
                else if (m_dir ? up != 0 : dn != 0) m_tgt = m_dir ? up : dn;
                else begin
                    m_tgt = m_dir ? dn : up;
                    m_dir = !m_dir;
                end
                m_tmo = 0;
                m_state = 1;
            end
            1: if (d && fl[m_tgt]) begin
                clr = m_tgt; m_tgt = 0; m_dw = DWELL; m_state = 2;
            end else begin
                m_tmo++;
                if (m_tmo == TIMEOUT) begin
                    m_tgt = 0; m_state = 3;
                end
            end
            2: begin
                if (m_dw > 0) m_dw--;
                if (m_dw == 0 && !d) m_state = 0;
            end
            default: if (fc) begin
                m_state = 0; m_tmo = 0;
            end
        endcase
        for (int f = 1; f <= 3; f++) begin
            if (f == clr) m_pend[f] = 1'b0;
            if (setb[f]) m_pend[f] = 1'b1;
            m_prev[f] = b[f];
        end
    endtask

    // drive one cycle of inputs, queue the model's post-edge outputs, return at edge+2
    task automatic step(input logic [3:1] b, input logic [3:1] fl, input logic d, input logic fc);
        Btn = b; {FLR3, FLR2, FLR1} = fl; Door = d; FaultClr = fc;
        model_step(b, fl, d, fc);
        expq.push_back(model_out());
        @(posedge clk);
        #2;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) chk("outputs{Req,Pend,Dir,Busy,Fault}", {Req, Pend, Dir, Busy, Fault}, expq.pop_front());
        end
    end

    logic [3:1] bad_flr[5];

    initial begin
        bad_flr[0] = 3'b000; bad_flr[1] = 3'b011; bad_flr[2] = 3'b101;
        bad_flr[3] = 3'b110; bad_flr[4] = 3'b111;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        Reset = 1'b0;
        chk("reset_state", {Req, Pend, Dir, Busy, Fault}, 9'b000_000_1_0_0);

        step(3'b100, 3'b001, 1'b0, 1'b0);
        chk("capture_pend", 9'(Pend), 9'(3'b100));
        step(3'b000, 3'b001, 1'b0, 1'b0);
        chk("issue_req", 9'({Req, Dir}), 9'({3'b100, 1'b1}));
        step(3'b000, 3'b100, 1'b1, 1'b0);
        chk("service_clear", 9'({Req, Pend}), 9'(6'b000_000));
        for (int i = 0; i < 6; i++) begin
            step(3'b000, 3'b100, 1'b0, 1'b0);
            chk("dwell_req_low", 9'(Req), 9'(3'b000));
        end

        step(3'b101, 3'b010, 1'b0, 1'b0);
        step(3'b000, 3'b010, 1'b0, 1'b0);
        chk("scan_up_keep", 9'({Req, Dir}), 9'({3'b100, 1'b1}));
        step(3'b000, 3'b100, 1'b1, 1'b0);
        chk("serve3_pend", 9'(Pend), 9'(3'b001));
        for (int i = 0; i < 6; i++) step(3'b000, 3'b100, 1'b0, 1'b0);
        chk("scan_reverse", 9'({Req, Dir}), 9'({3'b001, 1'b0}));

        step(3'b010, 3'b010, 1'b1, 1'b0);
        chk("door_discard", 9'(Pend), 9'(3'b001));
        step(3'b000, 3'b010, 1'b0, 1'b0);
        step(3'b010, 3'b001, 1'b1, 1'b0);
        chk("press_elsewhere", 9'({Req, Pend}), 9'({3'b000, 3'b010}));

        for (int i = 0; i < DWELL + 1 + TIMEOUT - 1; i++) step(3'b000, 3'b001, 1'b0, 1'b0);
        chk("pre_timeout", 9'({Req, Fault}), 9'({3'b010, 1'b0}));
        step(3'b000, 3'b001, 1'b0, 1'b0);
        chk("timeout_fault", 9'({Req, Pend, Fault}), 9'({3'b000, 3'b010, 1'b1}));
        step(3'b000, 3'b001, 1'b0, 1'b1);
        step(3'b000, 3'b001, 1'b0, 1'b0);
        chk("reissue", 9'({Req, Fault}), 9'({3'b010, 1'b0}));

        step(3'b000, 3'b010, 1'b1, 1'b0);
        step(3'b100, 3'b010, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(3'b000, 3'b011, 1'b0, 1'b0);
        chk("invalid_pos", 9'({Req, Pend, Busy}), 9'({3'b000, 3'b100, 1'b0}));
        step(3'b000, 3'b001, 1'b0, 1'b0);
        chk("valid_again", 9'(Req), 9'(3'b100));

        Reset = 1'b1;
        #1;
        chk("async_reset", {Req, Pend, Dir, Busy, Fault}, 9'b000_000_1_0_0);
        @(posedge clk);
        #2;
        Reset = 1'b0;
        model_reset();

        for (int i = 0; i < 3000; i++) begin
            logic [3:1] b, fl;
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) fl = bad_flr[$urandom_range(0, 4)];
            else if (r < 6 && m_tgt != 0) fl = 3'(1 << (m_tgt - 1));
            else fl = 3'(1 << $urandom_range(0, 2));
            for (int f = 1; f <= 3; f++) b[f] = ($urandom_range(0, 5) == 0);
            step(b, fl, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
        end

        repeat (2) @(posedge clk);
        #2;
        n_vec++;
        if (expq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
